// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_if
// Description : Request channel into the instruction encoder. It carries a
//               valid/ready handshake and the symbolic fields of one
//               instruction.
//               master : the request producer (bench / boot logic)
//               slave  : the encoder
//   in_valid  : request valid            in_ready  : encoder can accept
//   in_kind   : 0 DP reg, 1 DP imm, 2 LDR, 3 STR, 4 B, 5-7 illegal
//   in_cmd    : DP command               in_s      : DP S bit
//   in_cond   : condition field          in_rn/rd/rm : register fields
//   in_imm    : rot/imm8 or offset       in_target : branch word address
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic [3:0]        in_cond;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [3:0]        in_rm;
  logic [11:0]       in_imm;
  logic [ADDR_W-1:0] in_target;

  modport master (
    output in_valid, in_kind, in_cmd, in_s, in_cond, in_rn, in_rd, in_rm,
           in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_cmd, in_s, in_cond, in_rn, in_rd, in_rm,
           in_imm, in_target,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Accepts symbolic instruction requests, packs each one into a
//               32-bit machine word, and writes it to the next word of
//               instruction memory. One request is handled every two cycles:
//               the request is accepted in IDLE and written in WRITE.
// Ports       : clk, reset (sync, active high), clear (sync pointer restart)
//               req       : request channel (instr_encoder_if.slave)
//               imem_we/imem_addr/imem_wd : instruction-memory write port
//               count     : words written since reset/clear
//               full      : count == 2**ADDR_W, no further requests accepted
//               err       : sticky flag for an illegal request
// Parameters  : ADDR_W word-address width, supported range 1..21
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  instr_encoder_if.slave    req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [2:0] c_kind_dp_reg = 3'd0;
  localparam logic [2:0] c_kind_dp_imm = 3'd1;
  localparam logic [2:0] c_kind_ldr    = 3'd2;
  localparam logic [2:0] c_kind_str    = 3'd3;
  localparam logic [2:0] c_kind_b      = 3'd4;

  localparam logic [3:0] c_cmd_and = 4'b0000;
  localparam logic [3:0] c_cmd_sub = 4'b0010;
  localparam logic [3:0] c_cmd_add = 4'b0100;
  localparam logic [3:0] c_cmd_orr = 4'b1100;

  localparam logic [ADDR_W+1:0] c_pc_ahead = (ADDR_W+2)'(2);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0]        kind;
    logic [3:0]        cmd;
    logic              s;
    logic [3:0]        cond;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [3:0]        rm;
    logic [11:0]       imm;
    logic [ADDR_W-1:0] target;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic              w_kill;
  logic              w_accept;
  logic              w_legal;
  logic [1:0]        w_op;
  logic [5:0]        w_funct;
  logic [11:0]       w_src2;
  logic [ADDR_W+1:0] w_br_off;
  logic [31:0]       w_enc;

  assign w_kill = reset | clear;

  // count never exceeds 2**ADDR_W, so its top bit alone marks full.
  assign full        = count_q[ADDR_W];
  assign req.in_ready = (state_q == S_IDLE) & ~full & ~clear;
  assign w_accept    = req.in_valid & req.in_ready;

  always_comb begin
    w_legal = 1'b0;
    case (req_q.kind)
      c_kind_dp_reg, c_kind_dp_imm:
        w_legal = (req_q.cmd == c_cmd_add) | (req_q.cmd == c_cmd_sub) |
                  (req_q.cmd == c_cmd_and) | (req_q.cmd == c_cmd_orr);
      c_kind_ldr, c_kind_str, c_kind_b:
        w_legal = 1'b1;
      default:
        w_legal = 1'b0;
    endcase
  end

  // Branch offset is relative to the write address plus two words, worked
  // out two bits wider than the address so the sign survives.
  assign w_br_off = {2'b00, req_q.target} - {2'b00, count_q[ADDR_W-1:0]} - c_pc_ahead;

  always_comb begin
    w_op    = 2'b00;
    w_funct = 6'b000000;
    w_src2  = 12'h000;
    case (req_q.kind)
      c_kind_dp_reg: begin
        w_funct = {1'b0, req_q.cmd, req_q.s};
        w_src2  = {8'h00, req_q.rm};
      end
      c_kind_dp_imm: begin
        w_funct = {1'b1, req_q.cmd, req_q.s};
        w_src2  = req_q.imm;
      end
      c_kind_ldr: begin
        w_op    = 2'b01;
        w_funct = 6'b011001;
        w_src2  = req_q.imm;
      end
      c_kind_str: begin
        w_op    = 2'b01;
        w_funct = 6'b011000;
        w_src2  = req_q.imm;
      end
      default: begin
        w_op    = 2'b00;
        w_funct = 6'b000000;
        w_src2  = 12'h000;
      end
    endcase

    if (req_q.kind == c_kind_b) begin
      w_enc = {req_q.cond, 2'b10, 2'b10,
               {(22-ADDR_W){w_br_off[ADDR_W+1]}}, w_br_off};
    end else begin
      w_enc = {req_q.cond, w_op, w_funct, req_q.rn, req_q.rd, w_src2};
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    count_d = count_q;
    err_d   = err_q;
    imem_we = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          req_d.kind   = req.in_kind;
          req_d.cmd    = req.in_cmd;
          req_d.s      = req.in_s;
          req_d.cond   = req.in_cond;
          req_d.rn     = req.in_rn;
          req_d.rd     = req.in_rd;
          req_d.rm     = req.in_rm;
          req_d.imm    = req.in_imm;
          req_d.target = req.in_target;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (w_legal) begin
          imem_we = 1'b1;
          count_d = count_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A restart aborts any pending write in the same cycle.
    if (w_kill) begin
      state_d = S_IDLE;
      count_d = '0;
      err_d   = 1'b0;
      imem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr = count_q[ADDR_W-1:0];
  assign imem_wd   = imem_we ? w_enc : 32'h0000_0000;
  assign count     = count_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder. Directed steps plus a
//               randomized fill to capacity, checked against a behavioural
//               model of the instruction format and write-pointer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
  localparam int AW  = 6;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  instr_encoder_if #(.ADDR_W(AW)) ifc ();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .req       (ifc.slave),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  int m_count = 0;
  bit m_err   = 1'b0;

  // current request
  int c_k, c_c, c_s, c_cd, c_rn, c_rd, c_rm, c_imm, c_tgt;
  logic [31:0]   last_wd;
  logic [AW-1:0] last_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(int kind, int cmd);
    if (kind >= 2 && kind <= 4) return 1'b1;
    if (kind <= 1) return (cmd == 0) || (cmd == 2) || (cmd == 4) || (cmd == 12);
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_word(int kind, int cmd, int s, int cond,
                                             int rn, int rd, int rm, int imm,
                                             int target, int addr);
    logic [31:0] base;
    int off;
    base = (32'(cond) << 28) | (32'(rn) << 16) | (32'(rd) << 12);
    case (kind)
      0: return base | (32'(cmd) << 21) | (32'(s) << 20) | 32'(rm);
      1: return base | (32'h1 << 25) | (32'(cmd) << 21) | (32'(s) << 20) | 32'(imm);
      2: return base | (32'h1 << 26) | (32'h19 << 20) | 32'(imm);
      3: return base | (32'h1 << 26) | (32'h18 << 20) | 32'(imm);
      4: begin
        off = target - (addr + 2);
        return (32'(cond) << 28) | (32'hA << 24) | (32'(off) & 32'h00FF_FFFF);
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input int k, input int c, input int s, input int cd,
                       input int rn, input int rd, input int rm, input int imm,
                       input int tgt);
    c_k = k; c_c = c; c_s = s; c_cd = cd;
    c_rn = rn; c_rd = rd; c_rm = rm; c_imm = imm; c_tgt = tgt;
    ifc.in_kind   = 3'(k);
    ifc.in_cmd    = 4'(c);
    ifc.in_s      = 1'(s);
    ifc.in_cond   = 4'(cd);
    ifc.in_rn     = 4'(rn);
    ifc.in_rd     = 4'(rd);
    ifc.in_rm     = 4'(rm);
    ifc.in_imm    = 12'(imm);
    ifc.in_target = AW'(tgt);
    ifc.in_valid  = 1'b1;
  endtask

  // Called just after a falling edge with a request on the bus; returns just
  // after the falling edge of the cycle following the write.
  task automatic finish_req(input string tag);
    int n;
    bit lg;
    logic [31:0] exp_w;
    n = 0;
    #1;
    while (!ifc.in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!ifc.in_ready) begin
      chk({tag, ".accept_timeout"}, ifc.in_ready, 1);
      ifc.in_valid = 1'b0;
      return;
    end
    lg    = model_legal(c_k, c_c);
    exp_w = model_word(c_k, c_c, c_s, c_cd, c_rn, c_rd, c_rm, c_imm, c_tgt, m_count % CAP);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    last_wd   = imem_wd;
    last_addr = imem_addr;
    chk({tag, ".we"}, imem_we, lg);
    if (lg) begin
      chk({tag, ".addr"}, imem_addr, m_count % CAP);
      chk({tag, ".wd"}, imem_wd, exp_w);
    end
    chk({tag, ".ready_write"}, ifc.in_ready, 0);
    if (lg) m_count++;
    else m_err = 1'b1;
    @(negedge clk);
    chk({tag, ".count"}, count, m_count);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".ready_idle"}, ifc.in_ready, (m_count < CAP));
    chk({tag, ".full"}, full, (m_count == CAP));
  endtask

  task automatic send(input string tag, input int k, input int c, input int s,
                      input int cd, input int rn, input int rd, input int rm,
                      input int imm, input int tgt);
    drive(k, c, s, cd, rn, rd, rm, imm, tgt);
    finish_req(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int k, c;
    reset = 1'b1;
    clear = 1'b0;
    ifc.in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ifc.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.count", count, 0);
    chk("rst.err", err, 0);
    chk("rst.we", imem_we, 0);
    chk("rst.ready", ifc.in_ready, 1);
    chk("rst.full", full, 0);

    // directed programme
    send("add", 0, 4, 0, 14, 2, 1, 3, 0, 0);
    chk("add.hex", last_wd, 32'hE082_1003);
    send("subs_imm", 1, 2, 1, 14, 0, 0, 0, 1, 0);
    chk("subs_imm.hex", last_wd, 32'hE250_0001);
    send("ldr", 2, 0, 0, 14, 0, 2, 0, 4, 0);
    chk("ldr.hex", last_wd, 32'hE590_2004);
    send("str", 3, 0, 0, 14, 1, 2, 0, 8, 0);
    chk("str.hex", last_wd, 32'hE581_2008);
    send("b_back", 4, 0, 0, 14, 0, 0, 0, 0, 0);
    chk("b_back.hex", last_wd, 32'hEAFF_FFFA);
    chk("b_back.addr", last_addr, 4);
    send("b_fwd", 4, 0, 0, 14, 0, 0, 0, 0, 10);
    chk("b_fwd.hex", last_wd, 32'hEA00_0003);

    // illegal requests, then a legal one at the same address
    send("bad_cmd", 0, 15, 0, 14, 1, 1, 1, 0, 0);
    send("bad_kind", 6, 4, 0, 14, 1, 1, 1, 0, 0);
    send("after_bad", 0, 4, 0, 14, 2, 1, 3, 0, 0);
    chk("after_bad.addr", last_addr, 6);

    // clear during the write cycle aborts the write
    drive(0, 4, 0, 14, 2, 1, 3, 0, 0);
    #1;
    chk("cw.ready", ifc.in_ready, 1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    chk("cw.we", imem_we, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
    @(negedge clk);
    chk("cw.count", count, 0);
    chk("cw.err", err, 0);

    // held request is blocked while clear is high
    drive(0, 12, 1, 0, 3, 4, 5, 0, 0);
    clear = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold.ready", ifc.in_ready, 0);
      chk("hold.we", imem_we, 0);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    finish_req("hold_release");
    chk("hold_release.addr", last_addr, 0);

    // randomized fill to capacity
    guard = 0;
    while (m_count < CAP && guard < 400) begin
      guard++;
      k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0: c = 0;
        1: c = 2;
        2: c = 4;
        3: c = 12;
        default: c = int'($urandom_range(0, 15));
      endcase
      send("rnd", k, c, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, CAP - 1)));
    end
    chk("fill.count", count, CAP);
    chk("fill.full", full, 1);
    chk("fill.ready", ifc.in_ready, 0);

    // held request at full is never taken
    drive(0, 4, 0, 14, 7, 8, 9, 0, 0);
    repeat (4) begin
      @(negedge clk);
      chk("full_hold.we", imem_we, 0);
      chk("full_hold.ready", ifc.in_ready, 0);
      chk("full_hold.count", count, CAP);
    end
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
    @(negedge clk);
    chk("reclear.count", count, 0);
    chk("reclear.full", full, 0);
    finish_req("reclear_write");
    chk("reclear_write.addr", last_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential instruction encoder and program loader for the single-cycle ARM-subset core. It accepts symbolic instruction requests (kind, cmd, cond, registers, immediate, branch target) over a valid/ready handshake. Each accepted request is packed into a 32-bit machine word in the format the core's decoder consumes, and written to the next word of instruction memory. It is used by the bench and boot logic to load programs without hand-assembled hex.

Parameters:
ADDR_W, 6, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
clear  in  1  synchronous restart of the write pointer; same effect as reset on internal state
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request this cycle
in_kind  in  3  0=DP reg, 1=DP imm, 2=LDR, 3=STR, 4=B; 5-7 illegal
in_cmd  in  4  DP command: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other value is illegal for DP
in_s  in  1  S bit; used by DP only
in_cond  in  4  condition field
in_rn, in_rd, in_rm  in  4 each  register fields
in_imm  in  12  DP rot/imm8 or memory offset
in_target  in  ADDR_W  branch target, word address
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  write word address
imem_wd  out  32  encoded instruction
count  out  ADDR_W+1  words written since reset/clear
full  out  1  count == 2^ADDR_W
err  out  1  sticky illegal-request flag

Behaviour:
- States: IDLE, WRITE. Reset/clear → IDLE, count=0, err=0, imem_we=0, imem_addr=0, imem_wd=0.
- IDLE: in_ready = ~full & ~clear. Accept when in_valid & in_ready: register all fields, go to WRITE.
- WRITE: in_ready=0.
  - Legal request: imem_we=1 for exactly one cycle, imem_addr=count[ADDR_W-1:0], imem_wd=encoded word. At the clock edge, count increments. Next state is IDLE.
  - Illegal request (kind 5-7, or DP with unlisted cmd): imem_we=0, err set (sticky until reset/clear), count unchanged. Next state is IDLE.
- Throughput: one request per 2 cycles. Write occurs in the cycle after acceptance.
- Field layout: [31:28]=cond, [27:26]=op, [25:20]=funct, [19:16]=Rn, [15:12]=Rd, [11:0]=src2.
  - DP reg: op=00, funct={0,cmd,S}, src2={8'b0,Rm}.
  - DP imm: op=00, funct={1,cmd,S}, src2=imm.
  - LDR: op=01, funct=011001, src2=imm.
  - STR: op=01, funct=011000, src2=imm.
  - B: op=10, funct[5:4]=10, bits[23:0]=sign-extended offset, where offset = target − (addr+2). The offset is computed as an ADDR_W+2-bit signed value.
  - Rn, Rd, Rm are ignored for B. S is ignored for LDR/STR/B.
  - Rd=15 is allowed; no special handling.
- full: once count reaches 2^ADDR_W, in_ready stays 0 until reset or clear. There is no wrap and no overwrite.
- clear or reset in WRITE: abort, no write (imem_we=0 that cycle), go to IDLE with count=0.
- clear concurrent with in_valid in IDLE: clear wins; the request is not accepted.
- imem_wd and imem_addr are don't-care when imem_we=0.

Test Plan:
- Reset, then DP reg ADD cond=1110 rn=2 rd=1 rm=3 s=0 → one cycle later imem_we=1, addr=0, wd=E0821003; count=1; in_ready low for exactly 1 cycle.
- DP imm SUB s=1 rn=0 rd=0 imm=001 → wd=E2500001. Then LDR rn=0 rd=2 imm=004 → E5902004. Then STR rn=1 rd=2 imm=008 → E5812008. Writes land at consecutive addresses.
- B target=0 issued when count=4 → wd=EAFFFFFA at addr 4. B target=10 issued at count=5 → offset 3, wd=EA000003.
- DP with cmd=1111, then kind=6 → no imem_we, err=1 and stays 1, count unchanged. A following legal ADD is still written at the same address.
- ADDR_W=2: four legal writes → full=1, count=4, in_ready=0. A 5th request held valid is never accepted. Pulse clear → count=0, full=0, next write goes to addr 0.
- Assert clear in a WRITE cycle → imem_we=0 that cycle, count=0. Held-valid request with clear=1 in IDLE → not accepted until clear deasserts.
